// File: rtl/iob_rom_stream_if.sv
// Stream output bundle for iob_rom_stream.
// master drives valid/data/last; slave returns ready.
interface iob_rom_stream_if #(
    parameter int DATA_W = 8
) ();
    logic              o_valid;
    logic [DATA_W-1:0] o_data;
    logic              o_last;
    logic              o_ready;

    modport master (
        output o_valid,
        output o_data,
        output o_last,
        input  o_ready
    );

    modport slave (
        input  o_valid,
        input  o_data,
        input  o_last,
        output o_ready
    );
endinterface

// File: rtl/iob_rom_stream.sv
// Streams a burst of ROM words through a 2-entry output FIFO
// with valid/ready backpressure and abort.
module iob_rom_stream #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W:0]   length,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              r_en,
    output logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] r_data,
    iob_rom_stream_if.master  strm
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    localparam logic [ADDR_W:0] CNT_ZERO = '0;
    localparam logic [ADDR_W:0] CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};

    logic [1:0]        state;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W:0]   rcnt;
    logic [ADDR_W:0]   ocnt;
    logic              inflight;
    logic [1:0]        cnt;
    logic              wp;
    logic              rp;
    logic [DATA_W-1:0] mem [2];

    logic       pop;
    logic [1:0] occ;
    logic [1:0] occ_eff;
    logic       kill;

    assign pop     = strm.o_valid && strm.o_ready;
    assign occ     = cnt + {1'b0, inflight};
    assign occ_eff = occ - {1'b0, pop};
    assign kill    = abort && (state != IDLE);

    // Occupancy counts the in-flight read so the FIFO can never overflow.
    assign r_en = (state == RUN) && (rcnt != CNT_ZERO) && (occ_eff < 2'd2);
    assign addr = ptr;
    assign busy = (state != IDLE);

    assign strm.o_valid = (cnt != 2'd0);
    assign strm.o_data  = strm.o_valid ? mem[rp] : '0;
    assign strm.o_last  = strm.o_valid && (ocnt == CNT_ONE);

    always_ff @(posedge clk) begin
        if (inflight) mem[wp] <= r_data;
    end

    always_ff @(posedge clk) begin
        done <= 1'b0;
        if (rst || kill) begin
            state    <= IDLE;
            rcnt     <= '0;
            ocnt     <= '0;
            inflight <= 1'b0;
            cnt      <= '0;
            wp       <= 1'b0;
            rp       <= 1'b0;
            if (rst) ptr <= '0;
        end else begin
            inflight <= r_en;
            if (r_en) begin
                ptr  <= ptr + 1'b1;
                rcnt <= rcnt - CNT_ONE;
            end
            if (inflight) wp <= ~wp;
            if (pop) begin
                rp   <= ~rp;
                ocnt <= ocnt - CNT_ONE;
            end
            cnt <= cnt + {1'b0, inflight} - {1'b0, pop};
            case (state)
                IDLE: begin
                    if (start) begin
                        if (length != CNT_ZERO) begin
                            state <= RUN;
                            ptr   <= start_addr;
                            rcnt  <= length;
                            ocnt  <= length;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (r_en && (rcnt == CNT_ONE)) state <= DRAIN;
                end
                DRAIN: begin
                    if (pop && (ocnt == CNT_ONE)) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
